// File: rtl/sccb_boot_pkg.sv
// Shared definitions for the SCCB boot sequencer: table op codes, engine WR codes, FSM states.
package sccb_boot_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_DELAY = 2'b01;
    localparam logic [1:0] OP_RSVD  = 2'b10;
    localparam logic [1:0] OP_END   = 2'b11;

    localparam logic [3:0] SCCB_WR_WRITE = 4'h1;
    localparam logic [3:0] SCCB_WR_READ  = 4'h2;

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_SETTLE     = 4'd1;
    localparam logic [3:0] ST_FETCH      = 4'd2;
    localparam logic [3:0] ST_EXEC       = 4'd3;
    localparam logic [3:0] ST_XFER_ISSUE = 4'd4;
    localparam logic [3:0] ST_XFER_ACK   = 4'd5;
    localparam logic [3:0] ST_XFER_WAIT  = 4'd6;
    localparam logic [3:0] ST_DELAY      = 4'd7;
    localparam logic [3:0] ST_HOST       = 4'd8;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] data;
    } tbl_entry_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sccb_boot_rom.sv
// Synchronous 1-cycle init table. Contents are written through the load port by the boot loader.
module sccb_boot_rom
    import sccb_boot_pkg::*;
#(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    output tbl_entry_t    data,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  tbl_entry_t    load_data
);

    tbl_entry_t mem [2**AW];

    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_addr] <= load_data;
        data <= mem[addr];
    end

endmodule

// File: rtl/sccb_boot_sequencer.sv
// Replays the camera init table into the SCCB engine, then hands the engine to the host port.
// Optional SCCB_VERIFY_EN: read back every written register and flag mismatches.
module sccb_boot_sequencer
    import sccb_boot_pkg::*;
#(
    parameter int          TABLE_AW   = 6,
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int          SETTLE_CYC = 524288,
    parameter int          MS_CYC     = 100000,
    parameter int          ACK_TMO    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cam_rdy,
    input  logic                rerun,
    output logic [TABLE_AW-1:0] tbl_addr,
    input  logic [17:0]         tbl_data,
    input  logic                host_start,
    input  logic [3:0]          host_wr,
    input  logic [31:0]         host_data,
    output logic                host_busy,
    output logic [7:0]          host_rdata,
    output logic                sccb_start,
    output logic [3:0]          sccb_wr,
    output logic [31:0]         sccb_data,
    input  logic                sccb_busy,
    input  logic [7:0]          sccb_rdata,
    output logic                done,
    output logic                err,
    output logic [7:0]          err_count
);

    localparam logic [TABLE_AW-1:0] LAST = '1;

    logic [3:0]  state;
    logic [31:0] cnt;
    logic [31:0] dly_tgt;
    logic [3:0]  cmd_wr;
    logic [31:0] cmd_data;
    logic        step;
    logic        bump;
    logic        is_host;
    tbl_entry_t  ent;
`ifdef SCCB_VERIFY_EN
    logic        rd_phase;
`endif

    assign ent     = tbl_data;
    assign is_host = (state == ST_HOST);

    assign sccb_start = is_host ? host_start : (state == ST_XFER_ISSUE);
    assign sccb_wr    = is_host ? host_wr    : cmd_wr;
    assign sccb_data  = is_host ? host_data  : cmd_data;
    assign host_busy  = is_host ? sccb_busy  : 1'b1;
    assign host_rdata = is_host ? sccb_rdata : 8'h00;

    // step: current entry finished, move on; bump: count one error
    always_comb begin
        step = 1'b0;
        bump = 1'b0;
        case (state)
            ST_EXEC: begin
                if (cam_rdy && ent.op == OP_DELAY && ent.data == 8'h00)
                    step = 1'b1;
                if (cam_rdy && ent.op == OP_RSVD) begin
                    step = 1'b1;
                    bump = 1'b1;
                end
            end
            ST_XFER_ACK: begin
                if (!sccb_busy && cnt == 32'(ACK_TMO - 1)) begin
                    step = 1'b1;
                    bump = 1'b1;
                end
            end
            ST_XFER_WAIT: begin
`ifdef SCCB_VERIFY_EN
                if (!sccb_busy && rd_phase) begin
                    step = 1'b1;
                    bump = (sccb_rdata != cmd_data[7:0]);
                end
`else
                if (!sccb_busy)
                    step = 1'b1;
`endif
            end
            ST_DELAY: begin
                if (cnt == dly_tgt)
                    step = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tbl_addr  <= '0;
            cnt       <= '0;
            dly_tgt   <= '0;
            cmd_wr    <= 4'h0;
            cmd_data  <= 32'h0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'h00;
`ifdef SCCB_VERIFY_EN
            rd_phase  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    tbl_addr <= '0;
                    cnt      <= '0;
                    if (cam_rdy)
                        state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (!cam_rdy)
                        state <= ST_IDLE;
                    else if (cnt == 32'(SETTLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= ST_FETCH;
                    end else
                        cnt <= cnt + 32'd1;
                end
                ST_FETCH: begin
                    if (!cam_rdy) begin
                        state    <= ST_IDLE;
                        tbl_addr <= '0;
                    end else
                        state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (!cam_rdy) begin
                        state    <= ST_IDLE;
                        tbl_addr <= '0;
                    end else begin
                        case (ent.op)
                            OP_WRITE: begin
                                cmd_wr   <= SCCB_WR_WRITE;
                                cmd_data <= {8'h00, DEV_ID, ent.addr, ent.data};
                                state    <= ST_XFER_ISSUE;
`ifdef SCCB_VERIFY_EN
                                rd_phase <= 1'b0;
`endif
                            end
                            OP_DELAY: begin
                                if (ent.data != 8'h00) begin
                                    cnt     <= '0;
                                    dly_tgt <= 32'(ent.data) * 32'(MS_CYC) - 32'd1;
                                    state   <= ST_DELAY;
                                end
                            end
                            OP_END: begin
                                done  <= 1'b1;
                                state <= ST_HOST;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_XFER_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_XFER_ACK;
                end
                ST_XFER_ACK: begin
                    if (sccb_busy)
                        state <= ST_XFER_WAIT;
                    else
                        cnt <= cnt + 32'd1;
                end
                ST_XFER_WAIT: begin
`ifdef SCCB_VERIFY_EN
                    if (!sccb_busy && !rd_phase) begin
                        rd_phase <= 1'b1;
                        cmd_wr   <= SCCB_WR_READ;
                        state    <= ST_XFER_ISSUE;
                    end
`endif
                end
                ST_DELAY: begin
                    if (!cam_rdy) begin
                        state    <= ST_IDLE;
                        tbl_addr <= '0;
                    end else
                        cnt <= cnt + 32'd1;
                end
                ST_HOST: begin
                    if (rerun && !sccb_busy) begin
                        done     <= 1'b0;
                        tbl_addr <= '0;
                        state    <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // a transfer that outlived cam_rdy still aborts here, never wraps past the last entry
            if (step) begin
                if (!cam_rdy) begin
                    state    <= ST_IDLE;
                    tbl_addr <= '0;
                end else if (tbl_addr == LAST) begin
                    err   <= 1'b1;
                    done  <= 1'b1;
                    state <= ST_HOST;
                end else begin
                    tbl_addr <= tbl_addr + 1'b1;
                    state    <= ST_FETCH;
                end
            end
            if (bump) begin
                err       <= 1'b1;
                err_count <= sat_inc(err_count);
            end
        end
    end

endmodule

// File: tb/tb_sccb_boot_sequencer.sv
// Bench for sccb_boot_sequencer: transaction-level table model, engine model and per-cycle monitor.
module tb_sccb_boot_sequencer;
    import sccb_boot_pkg::*;

    localparam int         AW       = 6;
    localparam int         SETTLE   = 40;
    localparam int         MS       = 10;
    localparam int         TMO      = 16;
    localparam int         BUSY_LEN = 20;
    localparam logic [7:0] DEV      = 8'h42;
`ifdef SCCB_VERIFY_EN
    localparam int NXF = 2;
`else
    localparam int NXF = 1;
`endif

    logic          clk = 1'b0;
    logic          reset, cam_rdy, rerun;
    logic [AW-1:0] tbl_addr;
    tbl_entry_t    rom_q;
    logic          host_start;
    logic [3:0]    host_wr;
    logic [31:0]   host_data;
    logic          host_busy;
    logic [7:0]    host_rdata;
    logic          sccb_start;
    logic [3:0]    sccb_wr;
    logic [31:0]   sccb_data;
    logic          sccb_busy;
    logic [7:0]    sccb_rdata;
    logic          done, err;
    logic [7:0]    err_count;
    logic          load_en;
    logic [AW-1:0] load_addr;
    tbl_entry_t    load_data;

    always #5 clk = ~clk;

    sccb_boot_sequencer #(.TABLE_AW(AW), .DEV_ID(DEV), .SETTLE_CYC(SETTLE),
                          .MS_CYC(MS), .ACK_TMO(TMO)) dut (
        .clk(clk), .reset(reset), .cam_rdy(cam_rdy), .rerun(rerun),
        .tbl_addr(tbl_addr), .tbl_data(rom_q),
        .host_start(host_start), .host_wr(host_wr), .host_data(host_data),
        .host_busy(host_busy), .host_rdata(host_rdata),
        .sccb_start(sccb_start), .sccb_wr(sccb_wr), .sccb_data(sccb_data),
        .sccb_busy(sccb_busy), .sccb_rdata(sccb_rdata),
        .done(done), .err(err), .err_count(err_count));

    sccb_boot_rom #(.AW(AW)) rom (
        .clk(clk), .addr(tbl_addr), .data(rom_q),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int v, input int lo, input int hi);
        n_chk++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic logic [35:0] cmdw(input logic [3:0] wr, input logic [7:0] a, input logic [7:0] d);
        return {wr, 8'h00, DEV, a, d};
    endfunction

    function automatic tbl_entry_t mk(input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
        tbl_entry_t e;
        e.op = op; e.addr = a; e.data = d;
        return e;
    endfunction

    // ---------------- table model (transaction level) ----------------
    tbl_entry_t  tbl [64];
    logic [35:0] exp_q [$];
    int          st_cyc [$];
    bit          exp_err;
    int          exp_cnt;

    task automatic model_bump();
        exp_err = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
    endtask

    // walk entries [0, limit); the first 'drop' engine transfers are never acknowledged
    task automatic model_run(input int drop, input bit corrupt, input int limit);
        int  n = 0;
        bit  ended = 1'b0;
        for (int i = 0; i < limit && !ended; i++) begin
            case (tbl[i].op)
                OP_WRITE: begin
                    exp_q.push_back(cmdw(SCCB_WR_WRITE, tbl[i].addr, tbl[i].data));
                    n++;
                    if (n <= drop) model_bump();
                    else begin
`ifdef SCCB_VERIFY_EN
                        exp_q.push_back(cmdw(SCCB_WR_READ, tbl[i].addr, tbl[i].data));
                        n++;
                        if (n <= drop) model_bump();
                        else if (corrupt && tbl[i].data != 8'h00) model_bump();
`else
                        if (corrupt) n = n + 0;
`endif
                    end
                end
                OP_RSVD: model_bump();
                OP_END:  ended = 1'b1;
                default: ;
            endcase
        end
        if (!ended && limit == 64) exp_err = 1'b1;
    endtask

    function automatic int stc(input int i);
        return (i < st_cyc.size()) ? st_cyc[i] : -100000;
    endfunction

    // ---------------- engine model ----------------
    logic [7:0] emem [256];
    int drop_left = 0;
    bit corrupt = 1'b0;
    int b_from = -1;
    int b_to = -2;

    initial begin
        for (int i = 0; i < 256; i++) emem[i] = 8'h00;
        sccb_busy = 1'b0;
        sccb_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (sccb_start === 1'b1) begin
                if (drop_left > 0) drop_left--;
                else begin
                    b_from = cyc + 1;
                    b_to = cyc + BUSY_LEN;
                    if (sccb_wr == SCCB_WR_WRITE) emem[sccb_data[15:8]] = sccb_data[7:0];
                    else if (sccb_wr == SCCB_WR_READ)
                        sccb_rdata = corrupt ? 8'h00 : emem[sccb_data[15:8]];
                end
            end
            sccb_busy = (cyc >= b_from && cyc <= b_to);
        end
    end

    // ---------------- per-cycle monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset === 1'b0) begin
                if (done === 1'b1) begin
                    check("host_busy_follow", host_busy, sccb_busy);
                    check("host_rdata_follow", host_rdata, sccb_rdata);
                end else
                    check("host_busy_hold", host_busy, 1'b1);
                if (sccb_start === 1'b1) begin
                    st_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL start_unexpected: got %0h expected none", {sccb_wr, sccb_data});
                    end else
                        check("start_cmd", {sccb_wr, sccb_data}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input logic v, input int budget, input string name);
        int i = 0;
        while (done !== v && i < budget) begin
            tick(1);
            i++;
        end
        if (done !== v) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout, done=%0b expected %0b", name, done, v);
        end
    endtask

    task automatic load_and_reset();
        reset = 1'b1; cam_rdy = 1'b0; rerun = 1'b0;
        host_start = 1'b0; host_wr = 4'h0; host_data = 32'h0;
        tick(30);
        for (int i = 0; i < 64; i++) begin
            load_en = 1'b1;
            load_addr = AW'(i);
            load_data = tbl[i];
            tick(1);
        end
        load_en = 1'b0;
        check("rst_tbl_addr", tbl_addr, 0);
        check("rst_start", sccb_start, 0);
        check("rst_wr", sccb_wr, 0);
        check("rst_data", sccb_data, 0);
        check("rst_host_busy", host_busy, 1);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        exp_q.delete();
        st_cyc.delete();
        exp_err = 1'b0;
        exp_cnt = 0;
        drop_left = 0;
        corrupt = 1'b0;
        reset = 1'b0;
        tick(2);
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < 64; i++) tbl[i] = mk(OP_END, 8'h00, 8'h00);
    endtask

    task automatic final_checks(input string tag);
        check({tag, "_done"}, done, 1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_err_count"}, err_count, exp_cnt);
        check({tag, "_exp_left"}, exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, n0;
        load_en = 1'b0; load_addr = '0; load_data = '0;

        // ---- T1: normal replay, host gating, pass-through, rerun ----
        clear_tbl();
        tbl[0] = mk(OP_WRITE, 8'h12, 8'h80);
        tbl[1] = mk(OP_DELAY, 8'h00, 8'h02);
        tbl[2] = mk(OP_WRITE, 8'h40, 8'hD0);
        tbl[3] = mk(OP_END,   8'h00, 8'h00);
        load_and_reset();
        model_run(0, 1'b0, 64);
        check("t1_model_len", exp_q.size(), 2 * NXF);
        check("t1_model_first", exp_q[0], 36'h1_0042_1280);
        check("t1_model_err", exp_err, 0);
        cam_rdy = 1'b1;
        tick(10);
        host_start = 1'b1; host_wr = SCCB_WR_WRITE; host_data = 32'hDEAD_BEEF;
        @(negedge clk); #1;
        check("t1_settle_host_start_dropped", sccb_start, 0);
        check("t1_settle_host_busy", host_busy, 1);
        tick(1);
        host_start = 1'b0;
        rerun = 1'b1;
        tick(1);
        rerun = 1'b0;
        wait_done(1'b1, 2000, "t1_done");
        final_checks("t1");
        check("t1_starts", st_cyc.size(), 2 * NXF);
        check_rng("t1_delay_gap", stc(NXF) - stc(NXF - 1), 2 * MS + 20, 2 * MS + 40);
        tick(5);
        host_start = 1'b1; host_wr = SCCB_WR_WRITE; host_data = 32'h0042_5511;
        exp_q.push_back(cmdw(SCCB_WR_WRITE, 8'h55, 8'h11));
        @(negedge clk); #1;
        check("t1_host_start_pass", sccb_start, 1);
        check("t1_host_data_pass", sccb_data, 32'h0042_5511);
        check("t1_host_wr_pass", sccb_wr, SCCB_WR_WRITE);
        tick(1);
        host_start = 1'b0;
        tick(4);
        check("t1_host_busy_seen", host_busy, 1);
        tick(25);
        n0 = st_cyc.size();
        model_run(0, 1'b0, 64);
        rerun = 1'b1;
        r = cyc;
        tick(1);
        rerun = 1'b0;
        wait_done(1'b0, 10, "t1_rerun_clear");
        check("t1_rerun_addr", tbl_addr, 0);
        wait_done(1'b1, 2000, "t1_rerun_done");
        check_rng("t1_rerun_no_settle", stc(n0) - r, 2, 6);
        final_checks("t1r");

        // ---- T2: first WRITE never acknowledged ----
        clear_tbl();
        tbl[0] = mk(OP_WRITE, 8'h12, 8'h80);
        tbl[1] = mk(OP_WRITE, 8'h40, 8'hD0);
        tbl[2] = mk(OP_END,   8'h00, 8'h00);
        load_and_reset();
        model_run(1, 1'b0, 64);
        check("t2_model_cnt", exp_cnt, 1);
        check("t2_model_len", exp_q.size(), 1 + NXF);
        n0 = exp_q.size();
        drop_left = 1;
        cam_rdy = 1'b1;
        wait_done(1'b1, 2000, "t2_done");
        final_checks("t2");
        check("t2_starts", st_cyc.size(), n0);
        check_rng("t2_timeout_gap", stc(1) - stc(0), TMO, TMO + 6);

        // ---- T3: cam_rdy drop during DELAY ----
        clear_tbl();
        tbl[0] = mk(OP_WRITE, 8'h12, 8'h80);
        tbl[1] = mk(OP_DELAY, 8'h00, 8'h03);
        tbl[2] = mk(OP_WRITE, 8'h40, 8'hD0);
        tbl[3] = mk(OP_END,   8'h00, 8'h00);
        load_and_reset();
        model_run(0, 1'b0, 1);
        model_run(0, 1'b0, 64);
        cam_rdy = 1'b1;
        for (int i = 0; i < 500 && tbl_addr != 1; i++) tick(1);
        tick(8);
        cam_rdy = 1'b0;
        tick(3);
        check("t3_abort_addr", tbl_addr, 0);
        check("t3_abort_done", done, 0);
        tick(20);
        check("t3_abort_no_start", st_cyc.size(), NXF);
        r = cyc;
        cam_rdy = 1'b1;
        wait_done(1'b1, 2000, "t3_done");
        check_rng("t3_full_settle", stc(NXF) - r, SETTLE, SETTLE + 6);
        check("t3_starts", st_cyc.size(), 3 * NXF);
        final_checks("t3");

        // ---- T4: 64 WRITEs, no END ----
        for (int i = 0; i < 64; i++) tbl[i] = mk(OP_WRITE, 8'(i), 8'(i) ^ 8'h5A);
        load_and_reset();
        model_run(0, 1'b0, 64);
        check("t4_model_len", exp_q.size(), 64 * NXF);
        check("t4_model_err", exp_err, 1);
        cam_rdy = 1'b1;
        wait_done(1'b1, 64 * 60 * NXF, "t4_done");
        check("t4_starts", st_cyc.size(), 64 * NXF);
        check("t4_addr_last", tbl_addr, 6'h3F);
        final_checks("t4");

`ifdef SCCB_VERIFY_EN
        // ---- T5: readback mismatch ----
        clear_tbl();
        tbl[0] = mk(OP_WRITE, 8'h12, 8'h80);
        tbl[1] = mk(OP_END,   8'h00, 8'h00);
        load_and_reset();
        corrupt = 1'b1;
        model_run(0, 1'b1, 64);
        check("t5_model_cnt", exp_cnt, 1);
        cam_rdy = 1'b1;
        wait_done(1'b1, 2000, "t5_done");
        check("t5_starts", st_cyc.size(), 2);
        final_checks("t5");
`endif

        tick(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
